adder_share_arb: RTL and testbench

- Round-robin arbiter and pipeline sequencer sharing one registered wide adder among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one pair per cycle and drives it through a two-stage pipeline: operand registers, then sum register.
- It returns the sum tagged with the requester index on a single valid/ready result channel with full backpressure.
- Sits between benchmark traffic generators and the wide adder datapath in the arithmetic benchmark set.

---
 rtl/adder_share_arb_pkg.sv | 16 +
 rtl/adder_share_arb_if.sv | 30 +++
 rtl/rr_pick.sv | 31 +++
 rtl/adder_share_arb.sv | 115 +++++++++++
 tb/tb_adder_share_arb.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_arb_pkg.sv
// Shared constants and helpers for the adder_share_arb slice.
// Optional statistics counters are compiled in with ADDER_ARB_STATS_EN.
package adder_share_arb_pkg;

  localparam int ADDER_WIDTH_DEF = 118;
  localparam int NUM_REQ_DEF     = 4;
  localparam int IDX_W_DEF       = 2;
  localparam int STAT_W          = 32;

  // Counters stick at all-ones instead of wrapping to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value,
                                                input logic              en);
    return (en && (value != '1)) ? value + 1'b1 : value;
  endfunction

endpackage

// File: rtl/adder_share_arb_if.sv
// Requester and result channels of the shared-adder arbiter.
// The master side drives requests and result backpressure; the arbiter is the slave.
interface adder_share_arb_if
  import adder_share_arb_pkg::*;
#(
  parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int IDX_W       = IDX_W_DEF
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a;
  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b;
  logic                           res_valid;
  logic                           res_ready;
  logic [ADDER_WIDTH:0]           res_sum;
  logic [IDX_W-1:0]               res_idx;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_idx
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_idx
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter feeding one shared registered adder: operand stage, then sum stage.
// Define ADDER_ARB_STATS_EN to add the stat_grants/stat_stalls counters.
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  adder_share_arb_if.slave  bus
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0] stat_stalls
`endif
);

  logic                   s1_valid;
  logic [ADDER_WIDTH-1:0] s1_a;
  logic [ADDER_WIDTH-1:0] s1_b;
  logic [IDX_W-1:0]       s1_idx;
  logic [IDX_W-1:0]       rr_ptr;
  logic                   res_valid_q;
  logic [ADDER_WIDTH:0]   res_sum_q;
  logic [IDX_W-1:0]       res_idx_q;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       win_idx;
  logic                   any_req;
  logic                   adv2;
  logic                   can_load;
  logic                   accept;
  logic [IDX_W-1:0]       next_ptr;
  logic [ADDER_WIDTH-1:0] sel_a;
  logic [ADDER_WIDTH-1:0] sel_b;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (any_req)
  );

  // The operand stage may reload in the same cycle it hands its pair forward.
  assign adv2          = s1_valid & (~res_valid_q | bus.res_ready);
  assign can_load      = ~s1_valid | adv2;
  assign accept        = can_load & any_req & ~reset;
  assign bus.req_ready = accept ? grant : '0;
  assign next_ptr      = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[i*ADDER_WIDTH +: ADDER_WIDTH];
        sel_b = bus.req_b[i*ADDER_WIDTH +: ADDER_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_idx      <= '0;
      rr_ptr      <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_idx_q   <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= sel_a;
        s1_b     <= sel_b;
        s1_idx   <= win_idx;
        rr_ptr   <= next_ptr;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end

      if (adv2) begin
        res_sum_q   <= {1'b0, s1_a} + {1'b0, s1_b};
        res_idx_q   <= s1_idx;
        res_valid_q <= 1'b1;
      end else if (res_valid_q & bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_idx   = res_idx_q;

`ifdef ADDER_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      stat_grants <= sat_inc(stat_grants, accept);
      stat_stalls <= sat_inc(stat_stalls, res_valid_q & ~bus.res_ready);
    end
  end
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: directed phases plus random traffic vs a queue model.
// Stats checks are compiled in when ADDER_ARB_STATS_EN is defined.
module tb_adder_share_arb;
  import adder_share_arb_pkg::*;

  localparam int AW = 118;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef logic [AW:0] wide_t;
  typedef struct packed {
    logic [AW:0]   sum;
    logic [IW-1:0] idx;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adder_share_arb_if #(.ADDER_WIDTH(AW), .NUM_REQ(N), .IDX_W(IW)) bus ();

`ifdef ADDER_ARB_STATS_EN
  logic [STAT_W-1:0] stat_grants;
  logic [STAT_W-1:0] stat_stalls;
`endif

  adder_share_arb #(.ADDER_WIDTH(AW), .NUM_REQ(N), .IDX_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ADDER_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
`endif
  );

  logic [N-1:0]  vld;
  logic [AW-1:0] op_a [N];
  logic [AW-1:0] op_b [N];
  logic          rdy;

  // Reference model: accepted items in order; the head sits in the sum register when out_full.
  item_t pend[$];
  bit    out_full;
  int    ptr;
  int    m_grants, m_stalls;
  int    last_win;
  logic [N-1:0] obs_ready;

  int n_vec = 0;
  int n_err = 0;

  task automatic checkOutput(input string tag, input wide_t got, input wide_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_op();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 7) == 0) t = '1;
    return t[AW-1:0];
  endfunction

  task automatic new_ops(input int i);
    op_a[i] = rand_op();
    op_b[i] = rand_op();
  endtask

  function automatic int model_win();
    for (int k = 0; k < N; k++) begin
      if (vld[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Drive the current stimulus, check one cycle, advance the model across the edge.
  task automatic applyStimulus();
    int win;
    bit s1_full, adv, can, acc;
    logic [N-1:0] exp_rdy;
    item_t it;
    bus.req_valid = vld;
    bus.res_ready = rdy;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*AW +: AW] = op_a[i];
      bus.req_b[i*AW +: AW] = op_b[i];
    end
    #1;
    win     = model_win();
    s1_full = pend.size() > (out_full ? 1 : 0);
    adv     = s1_full && (!out_full || rdy);
    can     = !s1_full || adv;
    acc     = can && (win >= 0) && !reset;
    exp_rdy = acc ? N'(1) << win : '0;
    obs_ready = bus.req_ready;
    checkOutput("req_ready", wide_t'(bus.req_ready), wide_t'(exp_rdy));
    checkOutput("res_valid", wide_t'(bus.res_valid), wide_t'(out_full));
    if (out_full) begin
      checkOutput("res_sum", bus.res_sum, pend[0].sum);
      checkOutput("res_idx", wide_t'(bus.res_idx), wide_t'(pend[0].idx));
    end
    @(posedge clk);
    last_win = -1;
    if (reset) begin
      pend.delete();
      out_full = 1'b0;
      ptr      = 0;
      m_grants = 0;
      m_stalls = 0;
    end else begin
      if (out_full && !rdy) m_stalls++;
      if (out_full && rdy) void'(pend.pop_front());
      out_full = adv || (out_full && !rdy);
      if (acc) begin
        it.sum = wide_t'(op_a[win]) + wide_t'(op_b[win]);
        it.idx = IW'(win);
        pend.push_back(it);
        ptr = (win + 1) % N;
        m_grants++;
        last_win = win;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    vld   = '1;
    rdy   = 1'b1;
    repeat (cycles) applyStimulus();
    reset = 1'b0;
    vld   = '0;
  endtask

  task automatic check_stats();
`ifdef ADDER_ARB_STATS_EN
    checkOutput("stat_grants", wide_t'(stat_grants), wide_t'(m_grants));
    checkOutput("stat_stalls", wide_t'(stat_stalls), wide_t'(m_stalls));
`endif
  endtask

  initial begin
    int cnt;
    wide_t held;
    reset    = 1'b1;
    vld      = '0;
    rdy      = 1'b0;
    out_full = 1'b0;
    ptr      = 0;
    m_grants = 0;
    m_stalls = 0;
    last_win = -1;
    for (int i = 0; i < N; i++) new_ops(i);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset then idle.
    do_reset(2);
    checkOutput("reset_sum", bus.res_sum, '0);
    checkOutput("reset_idx", wide_t'(bus.res_idx), '0);
    repeat (10) applyStimulus();
    check_stats();

    // Single request with a carry into the MSB.
    vld     = 4'b0100;
    op_a[2] = AW'(1);
    op_b[2] = '1;
    rdy     = 1'b1;
    applyStimulus();
    vld = '0;
    applyStimulus();
    checkOutput("single_valid", wide_t'(bus.res_valid), wide_t'(1));
    checkOutput("single_sum", bus.res_sum, wide_t'(1) << AW);
    checkOutput("single_idx", wide_t'(bus.res_idx), wide_t'(2));
    repeat (2) applyStimulus();

    // All requesters valid with a free-flowing result channel.
    do_reset(1);
    vld = '1;
    rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus();
      checkOutput("grant_order", wide_t'(obs_ready), wide_t'(1) << (k % N));
      if (last_win >= 0) new_ops(last_win);
    end
`ifdef ADDER_ARB_STATS_EN
    checkOutput("grants_8", wide_t'(stat_grants), wide_t'(8));
`endif
    vld = '0;
    repeat (3) applyStimulus();

    // Backpressure from an empty pipeline admits exactly two pairs.
    vld = '1;
    rdy = 1'b0;
    cnt = 0;
    held = '0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      if (obs_ready != '0) cnt++;
      if (last_win >= 0) new_ops(last_win);
      if (k == 2) held = bus.res_sum;
    end
    checkOutput("bp_accepts", wide_t'(cnt), wide_t'(2));
    checkOutput("bp_ready_low", wide_t'(obs_ready), '0);
    checkOutput("bp_sum_held", bus.res_sum, held);
    check_stats();
    vld = '0;
    rdy = 1'b1;
    repeat (4) applyStimulus();

    // Fairness: requester 3 wins alone at ptr 0, then the pointer wraps to 0.
    do_reset(1);
    vld = 4'b1000;
    applyStimulus();
    checkOutput("fair_r3", wide_t'(obs_ready), wide_t'(4'b1000));
    vld = 4'b0011;
    applyStimulus();
    checkOutput("fair_wrap", wide_t'(obs_ready), wide_t'(4'b0001));
    vld = '0;
    repeat (3) applyStimulus();

    // Reset with results in flight discards them.
    do_reset(1);
    vld = '1;
    repeat (3) applyStimulus();
    do_reset(1);
    vld = 4'b0110;
    #1;
    checkOutput("flush_valid", wide_t'(bus.res_valid), '0);
    applyStimulus();
    checkOutput("flush_grant", wide_t'(obs_ready), wide_t'(4'b0010));
    vld = '0;
    repeat (3) applyStimulus();

    // Random traffic with random backpressure and occasional resets.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 1) == 1) begin
          new_ops(i);
          vld[i] = 1'b1;
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        applyStimulus();
        if (last_win >= 0) begin
          new_ops(last_win);
          vld[last_win] = ($urandom_range(0, 1) == 1);
        end
      end
    end
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
